// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream and instruction-memory write port bundle for imem_loader
// master is the loader side; slave is the byte source / memory side.
interface imem_loader_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                  in_valid;
  logic [7:0]            in_byte;
  logic                  in_ready;
  logic                  mem_we;
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata;

  modport master (
    input  in_valid,
    input  in_byte,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_valid,
    output in_byte,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a byte stream little-endian into words and writes them to instruction memory
// Holds the core stalled through busy while a program is loading.
module imem_loader #(
  parameter int addr_width  = 32,
  parameter int data_width  = 32,
  parameter int DEPTH_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [addr_width-1:0] i_num_words,
  imem_loader_if.master         bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_byte_cnt;
  logic [1:0]            w_byte_cnt_nxt;
  // Only the first three bytes are buffered; the fourth goes straight into the write word.
  logic [data_width-9:0] r_buf;
  logic [data_width-9:0] w_buf_nxt;
  logic [addr_width-1:0] r_word_idx;
  logic [addr_width-1:0] w_word_idx_nxt;
  logic [addr_width-1:0] w_word_idx_inc;
  logic [addr_width-1:0] r_count;
  logic [addr_width-1:0] w_count_nxt;
  logic [addr_width-1:0] r_mem_addr;
  logic [addr_width-1:0] w_mem_addr_nxt;
  logic [data_width-1:0] r_mem_wdata;
  logic [data_width-1:0] w_mem_wdata_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_error;
  logic                  w_error_nxt;

  assign w_word_idx_inc = r_word_idx + addr_width'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= 2'd0;
      r_buf       <= '0;
      r_word_idx  <= '0;
      r_count     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_buf       <= w_buf_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_count     <= w_count_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_buf_nxt       = r_buf;
    w_word_idx_nxt  = r_word_idx;
    w_count_nxt     = r_count;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_num_words == '0) begin
            w_done_nxt = 1'b1;
          end else if (i_num_words > addr_width'(DEPTH_WORDS)) begin
            w_error_nxt = 1'b1;
          end else begin
            w_count_nxt    = i_num_words;
            w_word_idx_nxt = '0;
            w_byte_cnt_nxt = 2'd0;
            w_state_nxt    = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (bus.in_valid) begin
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          case (r_byte_cnt)
            2'd0: w_buf_nxt[7:0]   = bus.in_byte;
            2'd1: w_buf_nxt[15:8]  = bus.in_byte;
            2'd2: w_buf_nxt[23:16] = bus.in_byte;
            default: begin
              w_mem_wdata_nxt = {bus.in_byte, r_buf};
              w_mem_addr_nxt  = r_word_idx;
              w_state_nxt     = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        w_word_idx_nxt = w_word_idx_inc;
        if (w_word_idx_inc == r_count) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == S_LOAD);
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word-packing model
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [31:0] i_num_words;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  imem_loader_if #(.addr_width(32), .data_width(32)) bus ();

  imem_loader #(.addr_width(32), .data_width(32), .DEPTH_WORDS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_num_words (i_num_words),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [7:0]  bq[$];
  int mcyc = 0;
  int done_n, err_n, viol_n, last_we_cyc, done_cyc;
  bit busy_seen, done_d;

  always @(negedge clk) begin
    mcyc++;
    if (rst_n) begin
      if (bus.mem_we) begin
        got_addr.push_back(bus.mem_addr);
        got_data.push_back(bus.mem_wdata);
        last_we_cyc = mcyc;
      end
      if (o_done) begin
        done_n++;
        done_cyc = mcyc;
      end
      if (o_error) err_n++;
      if (o_busy) busy_seen = 1'b1;
      if ((o_done && o_error) || ((o_done || o_error) && bus.mem_we)) viol_n++;
      if (done_d && o_busy) viol_n++;
      done_d = o_done;
    end
  end

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    done_n = 0; err_n = 0; viol_n = 0; busy_seen = 1'b0;
    last_we_cyc = 0; done_cyc = 0;
  endtask

  task automatic pulse_start(input logic [31:0] n);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_num_words = n;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_num_words = $urandom;
  endtask

  task automatic send_bytes(input int gap_max, input bit noisy);
    int t;
    for (int i = 0; i < bq.size(); i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          if (i % 4 != 0) check("in_ready_hold", bus.in_ready, 1);
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_byte  = bq[i];
      if (noisy) begin
        i_start     = 1'($urandom_range(0, 1));
        i_num_words = $urandom;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.in_ready && t < 30);
      if (!bus.in_ready) check("ready_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      i_start      = 1'b0;
    end
  endtask

  // Reference: word w is bytes 4w..4w+3, first byte in the low lane, written at index w.
  task automatic run_load(input string tag, input int n, input int gap_max, input bit noisy);
    int t;
    logic [31:0] exp_w;
    clear_mon();
    pulse_start(n);
    send_bytes(gap_max, noisy);
    t = 0;
    while (done_n == 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_cnt"}, done_n, 1);
    check({tag, "_err_cnt"}, err_n, 0);
    check({tag, "_nwrites"}, got_addr.size(), n);
    for (int w = 0; w < n && w < got_addr.size(); w++) begin
      exp_w = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
      check($sformatf("%s_addr%0d", tag, w), got_addr[w], w);
      check($sformatf("%s_data%0d", tag, w), got_data[w], exp_w);
    end
    check({tag, "_done_lat"}, done_cyc - last_we_cyc, 1);
    check({tag, "_viol"}, viol_n, 0);
    check({tag, "_idle_busy"}, o_busy, 0);
  endtask

  task automatic fill_random(input int n);
    bq.delete();
    for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
  endtask

  task automatic fill_prog2();
    bq = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_num_words = '0;
    bus.in_valid = 1'b0;
    bus.in_byte = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_busy", o_busy, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", bus.in_ready, 0);

    fill_prog2();
    run_load("prog2", 2, 0, 1'b0);
    check("prog2_w0", got_data.size() > 0 ? got_data[0] : 32'hX, 32'h00500513);
    check("prog2_w1", got_data.size() > 1 ? got_data[1] : 32'hX, 32'h00A00593);

    fill_prog2();
    run_load("prog2_gaps", 2, 3, 1'b0);

    clear_mon();
    pulse_start(32'd9);
    repeat (4) @(posedge clk);
    #1;
    check("ovf_err_cnt", err_n, 1);
    check("ovf_done_cnt", done_n, 0);
    check("ovf_nwrites", got_addr.size(), 0);
    check("ovf_busy_seen", busy_seen, 0);

    clear_mon();
    pulse_start($urandom_range(10, 1000));
    repeat (4) @(posedge clk);
    #1;
    check("ovf_big_err_cnt", err_n, 1);
    check("ovf_big_busy_seen", busy_seen, 0);

    clear_mon();
    pulse_start(32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("zero_done_cnt", done_n, 1);
    check("zero_err_cnt", err_n, 0);
    check("zero_nwrites", got_addr.size(), 0);
    check("zero_busy_seen", busy_seen, 0);

    clear_mon();
    pulse_start(32'd2);
    bq = '{8'hDE, 8'hAD};
    send_bytes(0, 1'b0);
    check("mid_busy_pre", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_mem_we", bus.mem_we, 0);
    check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0);
    check("arst_error", o_error, 0);
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_mem_wdata", bus.mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_idle_ready", bus.in_ready, 0);
    check("arst_nwrites", got_addr.size(), 0);
    bq = '{8'h6F, 8'h00, 8'h00, 8'h00};
    run_load("after_rst", 1, 0, 1'b0);
    check("after_rst_w0", got_data.size() > 0 ? got_data[0] : 32'hX, 32'h0000006F);

    bq.delete();
    for (int i = 0; i < 32; i++) bq.push_back(8'(i));
    run_load("full8", 8, 1, 1'b1);
    check("full8_addr7", got_data.size() > 7 ? got_data[7] : 32'hX, 32'h1F1E1D1C);

    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 8);
      fill_random(n);
      run_load($sformatf("rnd%0d", k), n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
